// File: rtl/branch_target_buffer_pkg.sv
// Processor-wide defaults and helpers shared by the branch predictors.
package branch_target_buffer_pkg;

  localparam int BTB_ADDR_WIDTH = 16;
  localparam int BTB_CTR_BITS   = 2;

  // Widest counter sat_ctr_next supports; callers zero-extend into this width
  // and truncate the result back to their own counter width.
  localparam int CTR_MAX_W = 8;

  // Saturating up/down step for a direction counter of 'width' bits.
  function automatic logic [CTR_MAX_W-1:0] sat_ctr_next(
    input logic [CTR_MAX_W-1:0] ctr,
    input logic                 taken,
    input int unsigned          width
  );
    logic [CTR_MAX_W-1:0] ctr_top;
    ctr_top = CTR_MAX_W'((64'd1 << width) - 64'd1);
    if (taken) begin
      return (ctr == ctr_top) ? ctr : ctr + CTR_MAX_W'(1);
    end
    return (ctr == '0) ? ctr : ctr - CTR_MAX_W'(1);
  endfunction

endpackage

// File: rtl/branch_target_buffer_priority_encoder.sv
// Lowest-set-bit encoder: returns the index of the lowest asserted request
// and whether any request is asserted at all.
module priority_encoder #(
  parameter int N = 2,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         any
);

  // Scan upward and latch onto the first set bit.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (req[i] && !any) begin
        idx = W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/branch_target_buffer.sv
// Fully associative branch target buffer with per-entry saturating direction
// counters. Lookup is combinational; updates, flush and reset land on the edge.
module branch_target_buffer
  import branch_target_buffer_pkg::*;
#(
  parameter int ADDR_WIDTH = BTB_ADDR_WIDTH,
  parameter int ENTRIES    = 32,
  parameter int CTR_BITS   = BTB_CTR_BITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  update,
  input  logic [ADDR_WIDTH-1:0] update_pc,
  input  logic [ADDR_WIDTH-1:0] update_target,
  input  logic                  update_taken,
  input  logic [ADDR_WIDTH-1:0] lookup_pc,
  output logic                  lookup_hit,
  output logic                  lookup_taken,
  output logic [ADDR_WIDTH-1:0] lookup_target
);

  localparam int IDX_W = $clog2(ENTRIES);

  logic [ENTRIES-1:0]    valid;
  logic [ADDR_WIDTH-1:0] tag    [ENTRIES];
  logic [ADDR_WIDTH-1:0] target [ENTRIES];
  logic [CTR_BITS-1:0]   ctr    [ENTRIES];
  logic [IDX_W-1:0]      victim;

  logic [ENTRIES-1:0] lookup_match;
  logic [ENTRIES-1:0] update_match;
  logic [IDX_W-1:0]   lookup_idx;
  logic [IDX_W-1:0]   update_idx;
  logic [IDX_W-1:0]   free_idx;
  logic [IDX_W-1:0]   alloc_idx;
  logic               lookup_any;
  logic               update_any;
  logic               free_any;
  logic [CTR_BITS-1:0] ctr_next;

  // Tag compare of every valid entry against both the fetch and resolve PCs.
  always_comb begin
    lookup_match = '0;
    update_match = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      lookup_match[i] = valid[i] && (tag[i] == lookup_pc);
      update_match[i] = valid[i] && (tag[i] == update_pc);
    end
  end

  priority_encoder #(.N(ENTRIES), .W(IDX_W)) u_lookup_pe (
    .req (lookup_match),
    .idx (lookup_idx),
    .any (lookup_any)
  );

  priority_encoder #(.N(ENTRIES), .W(IDX_W)) u_update_pe (
    .req (update_match),
    .idx (update_idx),
    .any (update_any)
  );

  priority_encoder #(.N(ENTRIES), .W(IDX_W)) u_free_pe (
    .req (~valid),
    .idx (free_idx),
    .any (free_any)
  );

  // Fetch-side prediction outputs, forced to zero on a miss.
  always_comb begin
    lookup_hit    = lookup_any;
    lookup_taken  = lookup_any && ctr[lookup_idx][CTR_BITS-1];
    lookup_target = lookup_any ? target[lookup_idx] : '0;
  end

  // Counter step for a hitting update and slot choice for an allocating one.
  always_comb begin
    ctr_next  = CTR_BITS'(sat_ctr_next(CTR_MAX_W'(ctr[update_idx]), update_taken, CTR_BITS));
    alloc_idx = free_any ? free_idx : victim;
  end

  // Table state: reset > flush > update; updates alongside flush/reset are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid  <= '0;
      victim <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        tag[i]    <= '0;
        target[i] <= '0;
        ctr[i]    <= '0;
      end
    end else if (flush) begin
      valid  <= '0;
      victim <= '0;
    end else if (update) begin
      if (update_any) begin
        ctr[update_idx] <= ctr_next;
        if (update_taken) begin
          target[update_idx] <= update_target;
        end
      end else begin
        valid[alloc_idx]  <= 1'b1;
        tag[alloc_idx]    <= update_pc;
        target[alloc_idx] <= update_target;
        ctr[alloc_idx]    <= update_taken ? '1 : '0;
        if (!free_any) begin
          victim <= (victim == IDX_W'(ENTRIES - 1)) ? '0 : victim + IDX_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Bench for branch_target_buffer: directed scenarios with literal expectations
// followed by a randomized stream, all checked against a table model.
module tb_branch_target_buffer;

  localparam int AW = 16;
  localparam int NE = 4;
  localparam int CB = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          update;
  logic [AW-1:0] update_pc;
  logic [AW-1:0] update_target;
  logic          update_taken;
  logic [AW-1:0] lookup_pc;
  logic          lookup_hit;
  logic          lookup_taken;
  logic [AW-1:0] lookup_target;

  always #5 clk = ~clk;

  branch_target_buffer #(.ADDR_WIDTH(AW), .ENTRIES(NE), .CTR_BITS(CB)) dut (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .update        (update),
    .update_pc     (update_pc),
    .update_target (update_target),
    .update_taken  (update_taken),
    .lookup_pc     (lookup_pc),
    .lookup_hit    (lookup_hit),
    .lookup_taken  (lookup_taken),
    .lookup_target (lookup_target)
  );

  int vectors     = 0;
  int miscompares = 0;
  bit chk         = 1'b0;

  // Reference table: plain integers, entries searched in index order.
  bit m_valid  [NE];
  int m_tag    [NE];
  int m_target [NE];
  int m_ctr    [NE];
  int m_victim;
  int u_hit, u_slot;
  int c_idx, c_hit, c_taken, c_target;

  function automatic int m_find(input int pc);
    for (int i = 0; i < NE; i++) begin
      if (m_valid[i] && m_tag[i] == pc) return i;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NE; i++) begin
        m_valid[i] = 0; m_tag[i] = 0; m_target[i] = 0; m_ctr[i] = 0;
      end
      m_victim = 0;
    end else if (flush) begin
      for (int i = 0; i < NE; i++) m_valid[i] = 0;
      m_victim = 0;
    end else if (update) begin
      u_hit = m_find(int'(update_pc));
      if (u_hit >= 0) begin
        if (update_taken) begin
          if (m_ctr[u_hit] < (1 << CB) - 1) m_ctr[u_hit] = m_ctr[u_hit] + 1;
          m_target[u_hit] = int'(update_target);
        end else if (m_ctr[u_hit] > 0) begin
          m_ctr[u_hit] = m_ctr[u_hit] - 1;
        end
      end else begin
        u_slot = -1;
        for (int i = 0; i < NE; i++) begin
          if (!m_valid[i] && u_slot < 0) u_slot = i;
        end
        if (u_slot < 0) begin
          u_slot   = m_victim;
          m_victim = (m_victim + 1) % NE;
        end
        m_valid[u_slot]  = 1;
        m_tag[u_slot]    = int'(update_pc);
        m_target[u_slot] = int'(update_target);
        m_ctr[u_slot]    = update_taken ? (1 << CB) - 1 : 0;
      end
    end
  end

  // Every-cycle comparison of the lookup port against the model.
  always @(negedge clk) begin
    if (chk) begin
      c_idx    = m_find(int'(lookup_pc));
      c_hit    = (c_idx >= 0) ? 1 : 0;
      c_taken  = (c_idx >= 0 && m_ctr[c_idx] >= (1 << (CB - 1))) ? 1 : 0;
      c_target = (c_idx >= 0) ? m_target[c_idx] : 0;
      vectors++;
      if (lookup_hit !== c_hit[0] || lookup_taken !== c_taken[0] ||
          lookup_target !== c_target[AW-1:0]) begin
        miscompares++;
        $display("FAIL model pc=%h: got hit=%b taken=%b target=%h, want hit=%0d taken=%0d target=%h",
                 lookup_pc, lookup_hit, lookup_taken, lookup_target, c_hit, c_taken, c_target[AW-1:0]);
      end
    end
  end

  task automatic cmp(input string name, input logic [AW+1:0] act, input logic [AW+1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got hit/taken/target=%h, want %h", name, act, exp);
    end
  endtask

  task automatic pin(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: model value %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input logic u, input logic [AW-1:0] pc, input logic [AW-1:0] tg,
                     input logic tk, input logic [AW-1:0] lpc);
    reset = 1'b0; flush = 1'b0; update = u;
    update_pc = pc; update_target = tg; update_taken = tk; lookup_pc = lpc;
    @(posedge clk); #1;
  endtask

  task automatic lit(input string name, input logic [AW-1:0] pc, input logic eh,
                     input logic et, input logic [AW-1:0] etg);
    reset = 1'b0; flush = 1'b0; update = 1'b0; lookup_pc = pc;
    @(negedge clk);
    cmp(name, {lookup_hit, lookup_taken, lookup_target}, {eh, et, etg});
  endtask

  initial begin
    // Reset with a concurrent update that must be discarded.
    reset = 1'b1; flush = 1'b0; update = 1'b1;
    update_pc = 16'h0100; update_target = 16'h0200; update_taken = 1'b1;
    lookup_pc = 16'h0100;
    @(posedge clk); #1;
    chk = 1'b1;
    lit("reset_clear", 16'h0100, 1'b0, 1'b0, 16'h0000);

    // Allocate and train down.
    cyc(1'b1, 16'h0040, 16'h0080, 1'b1, 16'h0040);
    lit("alloc_taken", 16'h0040, 1'b1, 1'b1, 16'h0080);
    cyc(1'b1, 16'h0040, 16'h1234, 1'b0, 16'h0040);
    lit("nt_once", 16'h0040, 1'b1, 1'b1, 16'h0080);
    cyc(1'b1, 16'h0040, 16'h1234, 1'b0, 16'h0040);
    lit("nt_twice", 16'h0040, 1'b1, 1'b0, 16'h0080);
    pin("ctr_after_nt", m_ctr[m_find(16'h0040)], 1);

    // Saturation at both ends.
    repeat (5) cyc(1'b1, 16'h0040, 16'h0080, 1'b1, 16'h0040);
    pin("ctr_sat_high", m_ctr[m_find(16'h0040)], 3);
    lit("sat_high", 16'h0040, 1'b1, 1'b1, 16'h0080);
    repeat (5) cyc(1'b1, 16'h0040, 16'h2222, 1'b0, 16'h0040);
    pin("ctr_sat_low", m_ctr[m_find(16'h0040)], 0);
    lit("sat_low", 16'h0040, 1'b1, 1'b0, 16'h0080);
    cyc(1'b1, 16'h0040, 16'h0080, 1'b1, 16'h0040);
    pin("ctr_up_one", m_ctr[m_find(16'h0040)], 1);
    lit("up_one", 16'h0040, 1'b1, 1'b0, 16'h0080);

    // Round-robin replacement on a full table.
    reset = 1'b1; update = 1'b0; flush = 1'b0;
    @(posedge clk); #1;
    for (int i = 1; i <= 4; i++) cyc(1'b1, 16'(i * 16), 16'(i * 16 + 256), 1'b1, 16'h0000);
    for (int i = 1; i <= 4; i++) lit("fill_hit", 16'(i * 16), 1'b1, 1'b1, 16'(i * 16 + 256));
    cyc(1'b1, 16'h0050, 16'h0150, 1'b1, 16'h0000);
    lit("evict_0x10", 16'h0010, 1'b0, 1'b0, 16'h0000);
    lit("new_0x50", 16'h0050, 1'b1, 1'b1, 16'h0150);
    pin("slot_0x50", m_find(16'h0050), 0);
    cyc(1'b1, 16'h0060, 16'h0160, 1'b1, 16'h0000);
    lit("evict_0x20", 16'h0020, 1'b0, 1'b0, 16'h0000);
    lit("new_0x60", 16'h0060, 1'b1, 1'b1, 16'h0160);
    pin("slot_0x60", m_find(16'h0060), 1);

    // Flush drops a concurrent update; next allocation takes slot 0.
    reset = 1'b0; flush = 1'b1; update = 1'b1;
    update_pc = 16'h0070; update_target = 16'h0170; update_taken = 1'b1;
    @(posedge clk); #1;
    lit("flush_0x70", 16'h0070, 1'b0, 1'b0, 16'h0000);
    lit("flush_0x50", 16'h0050, 1'b0, 1'b0, 16'h0000);
    lit("flush_0x30", 16'h0030, 1'b0, 1'b0, 16'h0000);
    cyc(1'b1, 16'h0080, 16'h0180, 1'b1, 16'h0000);
    lit("alloc_0x80", 16'h0080, 1'b1, 1'b1, 16'h0180);
    pin("slot_0x80", m_find(16'h0080), 0);

    // No write-to-read bypass.
    reset = 1'b0; flush = 1'b0; update = 1'b1;
    update_pc = 16'h0090; update_target = 16'h0190; update_taken = 1'b0;
    lookup_pc = 16'h0090;
    #1;
    cmp("bypass_same", {lookup_hit, lookup_taken, lookup_target}, {1'b0, 1'b0, 16'h0000});
    @(posedge clk); #1;
    update = 1'b0;
    cmp("bypass_next", {lookup_hit, lookup_taken, lookup_target}, {1'b1, 1'b0, 16'h0190});

    // Randomized traffic over a small PC set so hits, evictions and re-allocations mix.
    repeat (3000) begin
      reset         = ($urandom_range(0, 99) == 0);
      flush         = ($urandom_range(0, 39) == 0);
      update        = ($urandom_range(0, 3) != 0);
      update_pc     = 16'h0100 + 16'($urandom_range(0, 9) * 4);
      update_target = 16'($urandom);
      update_taken  = 1'($urandom_range(0, 1));
      lookup_pc     = 16'h0100 + 16'($urandom_range(0, 10) * 4);
      @(posedge clk); #1;
    end

    @(negedge clk);
    chk = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
